fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the RISC-V core, placed between instruction memory and the ID stage. It generates sequential PCs and issues pipelined requests to instruction memory. Returned instructions are buffered with their PCs in a FIFO of FIFO_DEPTH entries and handed to ID over a valid/ready handshake, so decode stalls never stall memory. A redirect from a later stage flushes the buffer and discards wrong-path responses still in flight.

---
 rtl/fetch_unit_if.sv | 44 ++++
 rtl/fetch_unit.sv | 124 ++++++++++++
 tb/tb_fetch_unit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: handshake bundle of the instruction-fetch front end.
//   master : the fetch unit (drives memory requests and the ID-side stream)
//   slave  : the environment (instruction memory, redirect source, ID stage)
// Signals:
//   imem_req_valid/ready/addr : request channel to instruction memory
//   imem_rsp_valid/data       : in-order response channel from memory
//   redirect_valid/pc         : fetch redirect from a later stage
//   id_valid/ready/instr/pc   : buffered instruction stream to ID
//   fifo_count                : occupied instruction-buffer entries
interface fetch_unit_if #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            id_valid;
    logic            id_ready;
    logic [31:0]     id_instr;
    logic [XLEN-1:0] id_pc;
    logic [CW-1:0]   fifo_count;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output id_valid, id_instr, id_pc, fifo_count,
        input  id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  id_valid, id_instr, id_pc, fifo_count,
        output id_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end between instruction memory and ID.
// Issues sequential, pipelined fetch requests, buffers returned words with
// their PCs in a FIFO_DEPTH-entry FIFO and presents them to ID over
// valid/ready. A redirect clears the buffer and discards wrong-path
// responses still in flight.
// Ports:
//   clk   : clock, all state on the rising edge
//   reset : synchronous, active-low
//   bus   : fetch_unit_if.master (memory request/response, redirect, ID stream)
//
// state | meaning
// IDLE  | one cycle after reset, no requests
// FETCH | normal operation, requests issued while credit is available
// FLUSH | draining wrong-path responses, no requests
module fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master bus
);
    localparam int              PW      = $clog2(FIFO_DEPTH);
    localparam int              CW      = PW + 1;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
    localparam logic [31:0]     NOP     = 32'h0000_0013;
    localparam logic [CW:0]     DEPTH_W = (CW+1)'(FIFO_DEPTH);
    localparam logic [PW-1:0]   PTR_ONE = PW'(1);

    typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [PW-1:0]   fifo_wr, fifo_rd;
    logic [PW-1:0]   pcq_wr, pcq_rd;
    logic [31:0]     fifo_instr [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_pc    [FIFO_DEPTH];
    logic [XLEN-1:0] pcq        [FIFO_DEPTH];

    logic            req_fire, rsp_fire, pop, push;
    logic [CW-1:0]   redir_drop, drop_next;

    // Credit covers both buffered and in-flight words, so every response
    // that is kept always finds a free FIFO slot.
    assign bus.imem_req_valid = (state == FETCH) &&
                                (({1'b0, count} + {1'b0, outstanding}) < DEPTH_W);
    assign bus.imem_req_addr  = pc;
    assign bus.id_valid       = (count != '0);
    assign bus.id_instr       = (count != '0) ? fifo_instr[fifo_rd] : NOP;
    assign bus.id_pc          = (count != '0) ? fifo_pc[fifo_rd] : '0;
    assign bus.fifo_count     = count;

    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    // A response with nothing outstanding is a protocol violation: ignore it.
    assign rsp_fire = bus.imem_rsp_valid && (outstanding != '0);
    assign pop      = bus.id_valid && bus.id_ready;
    assign push     = rsp_fire && (drop_cnt == '0) && !bus.redirect_valid;

    // Everything still in flight after this edge belongs to the old path.
    assign redir_drop = outstanding + CW'(req_fire) - CW'(rsp_fire);
    assign drop_next  = drop_cnt - CW'(rsp_fire && (drop_cnt != '0));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            fifo_wr     <= '0;
            fifo_rd     <= '0;
            pcq_wr      <= '0;
            pcq_rd      <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);

            // PC queue runs independently of redirects so dropped responses
            // still retire their entries in order.
            if (req_fire) begin
                pcq[pcq_wr] <= pc;
                pcq_wr      <= pcq_wr + PTR_ONE;
            end
            if (rsp_fire) begin
                pcq_rd <= pcq_rd + PTR_ONE;
            end

            if (push) begin
                fifo_instr[fifo_wr] <= bus.imem_rsp_data;
                fifo_pc[fifo_wr]    <= pcq[pcq_rd];
            end

            if (bus.redirect_valid) begin
                pc       <= bus.redirect_pc;
                count    <= '0;
                fifo_wr  <= '0;
                fifo_rd  <= '0;
                drop_cnt <= redir_drop;
                state    <= (redir_drop != '0) ? FLUSH : FETCH;
            end else begin
                if (req_fire) begin
                    pc <= pc + PC_STEP;
                end
                count    <= count + CW'(push) - CW'(pop);
                if (push) begin
                    fifo_wr <= fifo_wr + PTR_ONE;
                end
                if (pop) begin
                    fifo_rd <= fifo_rd + PTR_ONE;
                end
                drop_cnt <= drop_next;
                case (state)
                    IDLE:    state <= FETCH;
                    FETCH:   state <= FETCH;
                    FLUSH:   if (drop_next == '0) state <= FETCH;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// The bench acts as instruction memory (random in-order latency) and as the
// ID stage. Its reference model tags every accepted request with a path
// epoch; a redirect or reset starts a new epoch, and only responses of the
// current epoch (not arriving in a redirect cycle) enter the modelled buffer.
module tb_fetch_unit;
    localparam int          XLEN       = 32;
    localparam int          FIFO_DEPTH = 4;
    localparam logic [31:0] RESET_PC   = 32'hFFFF_FFF8;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic clk = 1'b0;
    logic reset = 1'b0;

    fetch_unit_if #(.XLEN(XLEN), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    mreq_t       memq[$];
    ent_t        fq[$];
    logic [31:0] req_log[$];
    logic [31:0] m_pc;
    bit          m_idle;
    bit          exp_req_valid;
    int          epoch;
    int          cyc;
    int          checks;
    int          failures;

    int lat_min, lat_max, rdy_pct, idr_pct, redir_pct, rst_pct;
    bit spur_en;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h0000_0013;
    endfunction

    function automatic bit stale_inflight();
        foreach (memq[i]) begin
            if (memq[i].epoch != epoch) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        memq.delete();
        fq.delete();
        m_pc          = RESET_PC;
        m_idle        = 1'b1;
        exp_req_valid = 1'b0;
        epoch++;
    endtask

    // One clock cycle: drive inputs, check outputs against the model just
    // before the edge, then advance the model across the edge.
    task automatic step(input bit rst_low, input bit redir, input logic [31:0] rpc);
        bit          rdy, idr, rspv, req_fire, pop;
        logic [31:0] rdata;
        mreq_t       e;

        rdy   = ($urandom_range(99) < rdy_pct);
        idr   = ($urandom_range(99) < idr_pct);
        rspv  = 1'b0;
        rdata = $urandom;
        if (memq.size() > 0) begin
            if (memq[0].due <= cyc) begin
                rspv  = 1'b1;
                rdata = mem_word(memq[0].addr);
            end
        end else if (spur_en) begin
            rspv = ($urandom_range(1) == 1);
        end

        reset              = !rst_low;
        bus.imem_req_ready = rdy;
        bus.imem_rsp_valid = rspv;
        bus.imem_rsp_data  = rdata;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.id_ready       = idr;

        #3;
        chk("req_valid",  32'(bus.imem_req_valid), 32'(exp_req_valid));
        chk("req_addr",   bus.imem_req_addr, m_pc);
        chk("fifo_count", 32'(bus.fifo_count), fq.size());
        chk("id_valid",   32'(bus.id_valid), 32'(fq.size() != 0));
        chk("id_pc",      bus.id_pc, (fq.size() != 0) ? fq[0].pc : 32'h0);
        chk("id_instr",   bus.id_instr, (fq.size() != 0) ? fq[0].instr : NOP);

        if (rst_low) begin
            model_reset();
        end else begin
            req_fire = exp_req_valid && rdy;
            pop      = (fq.size() != 0) && idr;
            if (pop) void'(fq.pop_front());
            if (rspv && memq.size() > 0) begin
                e = memq.pop_front();
                if (e.epoch == epoch && !redir) fq.push_back('{e.addr, rdata});
            end
            if (req_fire) begin
                memq.push_back('{m_pc, epoch, cyc + int'($urandom_range(lat_max, lat_min))});
                req_log.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
            if (redir) begin
                fq.delete();
                m_pc = rpc;
                epoch++;
            end
            m_idle        = 1'b0;
            exp_req_valid = !stale_inflight() && (fq.size() + memq.size() < FIFO_DEPTH);
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        int start;
        checks   = 0;
        failures = 0;
        epoch    = 0;
        cyc      = 0;
        lat_min  = 1; lat_max = 1;
        rdy_pct  = 100; idr_pct = 100;
        redir_pct = 0; rst_pct = 0;
        spur_en  = 1'b0;

        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.id_ready       = 1'b0;

        // Reset and stream through the top of the address space.
        reset = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        req_log.delete();
        run(20);
        chk("wrap_addr0", req_log[0], 32'hFFFF_FFF8);
        chk("wrap_addr1", req_log[1], 32'hFFFF_FFFC);
        chk("wrap_addr2", req_log[2], 32'h0000_0000);

        // Backpressure: credit limits in-flight plus buffered words.
        lat_min = 3; lat_max = 3; idr_pct = 0;
        step(1'b1, 1'b0, 32'h0);
        start = req_log.size();
        run(15);
        chk("credit_reqs",  req_log.size() - start, 4);
        chk("credit_count", 32'(bus.fifo_count), 32'd4);
        chk("credit_stall", 32'(bus.imem_req_valid), 32'd0);
        idr_pct = 100;
        step(1'b0, 1'b0, 32'h0);
        chk("resume_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("resume_addr",  bus.imem_req_addr, RESET_PC + 32'd16);
        idr_pct = 0;
        run(3);

        // Redirect with requests in flight.
        idr_pct = 100;
        step(1'b1, 1'b0, 32'h0);
        run(4);
        step(1'b0, 1'b1, 32'h0000_0100);
        chk("flush_no_req", 32'(bus.imem_req_valid), 32'd0);
        chk("flush_addr",   bus.imem_req_addr, 32'h0000_0100);
        run(15);

        // Random soak with redirects, resets, back-pressure and late responses.
        lat_min = 1; lat_max = 4; rdy_pct = 70; idr_pct = 60;
        redir_pct = 5; rst_pct = 1; spur_en = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            bit          rr, rd;
            logic [31:0] t;
            rr = ($urandom_range(99) < rst_pct);
            rd = ($urandom_range(99) < redir_pct);
            t  = $urandom;
            t[1:0] = 2'b00;
            if ($urandom_range(3) == 0) t = 32'hFFFF_FFF0;
            step(rr, rd, t);
        end

        // Reset while the buffer holds words and a flush is pending.
        lat_min = 2; lat_max = 2; rdy_pct = 100; idr_pct = 0; spur_en = 1'b0;
        step(1'b1, 1'b0, 32'h0);
        run(5);
        step(1'b0, 1'b1, 32'h0000_0200);
        step(1'b1, 1'b0, 32'h0);
        chk("mid_rst_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("mid_rst_count", 32'(bus.fifo_count), 32'd0);
        chk("mid_rst_instr", bus.id_instr, NOP);
        chk("mid_rst_addr",  bus.imem_req_addr, RESET_PC);
        spur_en = 1'b1; idr_pct = 100;
        run(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
